// File: rtl/ita_hwpe_addrgen.sv
// ita_hwpe_addrgen: strided 1D/2D/3D byte-address stream generator for one ITA HWPE stream.
// The 3D (d2) loop is only built when ITA_ADDRGEN_D2_EN is defined. Otherwise a
// dimension select of 1x behaves as 2D and d2_stride_i is ignored.
module ita_hwpe_addrgen #(
    parameter int unsigned AW = 32,
    parameter int unsigned LW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          req_start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [LW-1:0] tot_len_i,
    input  logic [AW-1:0] d0_stride_i,
    input  logic [LW-1:0] d0_len_i,
    input  logic [AW-1:0] d1_stride_i,
    input  logic [LW-1:0] d1_len_i,
    input  logic [AW-1:0] d2_stride_i,
    input  logic [1:0]    dim_enable_1h_i,
    output logic [AW-1:0] addr_o,
    output logic          addr_valid_o,
    input  logic          addr_ready_i,
    output logic          last_o,
    output logic          ready_start_o,
    output logic          done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, d0_stride_q, d1_stride_q;
    logic [LW-1:0] tot_len_q, d0_len_q, d1_len_q;
    logic          is2d_q, is3d;
    logic [AW-1:0] d0_off_q, d0_off_d, d1_off_q, d1_off_d, d2_off;
    logic [LW-1:0] beat_q, beat_d, d0_cnt_q, d0_cnt_d, d1_cnt_q, d1_cnt_d;
    logic [LW-1:0] d0_cnt_inc, d1_cnt_inc;
    logic          start, hs, last, d0_wrap, d1_wrap;

`ifdef ITA_ADDRGEN_D2_EN
    logic [AW-1:0] d2_stride_q, d2_off_q, d2_off_d;
    logic          is3d_q;
    assign is3d   = is3d_q;
    assign d2_off = d2_off_q;
`else
    logic unused_d2;
    assign unused_d2 = ^d2_stride_i;
    assign is3d      = 1'b0;
    assign d2_off    = '0;
`endif

    assign start      = (state_q == IDLE) && req_start_i;
    assign hs         = (state_q == RUN) && addr_ready_i;
    assign last       = (state_q == RUN) && (beat_q == tot_len_q - LW'(1));
    assign d0_cnt_inc = d0_cnt_q + LW'(1);
    assign d1_cnt_inc = d1_cnt_q + LW'(1);
    assign d0_wrap    = is2d_q && (d0_len_q != '0) && (d0_cnt_inc == d0_len_q);
    assign d1_wrap    = is3d && (d1_len_q != '0) && (d1_cnt_inc == d1_len_q);

    assign addr_o        = (state_q == RUN) ? base_q + d2_off + d1_off_q + d0_off_q : '0;
    assign addr_valid_o  = (state_q == RUN);
    assign last_o        = last;
    assign ready_start_o = (state_q == IDLE);
    assign done_o        = (state_q == DONE);

    // Next state: a zero-length job skips straight to DONE; DONE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_start_i) state_d = (tot_len_i != '0) ? RUN : DONE;
            RUN:     if (hs && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter/offset advance: offsets accumulate strides and wrap per dimension on each handshake.
    always_comb begin
        beat_d   = beat_q;
        d0_cnt_d = d0_cnt_q;
        d1_cnt_d = d1_cnt_q;
        d0_off_d = d0_off_q;
        d1_off_d = d1_off_q;
`ifdef ITA_ADDRGEN_D2_EN
        d2_off_d = d2_off_q;
`endif
        if (start) begin
            beat_d   = '0;
            d0_cnt_d = '0;
            d1_cnt_d = '0;
            d0_off_d = '0;
            d1_off_d = '0;
`ifdef ITA_ADDRGEN_D2_EN
            d2_off_d = '0;
`endif
        end else if (hs) begin
            beat_d   = beat_q + LW'(1);
            d0_off_d = d0_off_q + d0_stride_q;
            d0_cnt_d = d0_cnt_inc;
            if (d0_wrap) begin
                d0_off_d = '0;
                d0_cnt_d = '0;
                d1_off_d = d1_off_q + d1_stride_q;
                d1_cnt_d = d1_cnt_inc;
                if (d1_wrap) begin
                    d1_off_d = '0;
                    d1_cnt_d = '0;
`ifdef ITA_ADDRGEN_D2_EN
                    d2_off_d = d2_off_q + d2_stride_q;
`endif
                end
            end
        end
    end

    // State, counters and configuration latched at start; reset and clear abort any job.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q     <= IDLE;
            base_q      <= '0;
            d0_stride_q <= '0;
            d1_stride_q <= '0;
            tot_len_q   <= '0;
            d0_len_q    <= '0;
            d1_len_q    <= '0;
            is2d_q      <= 1'b0;
            beat_q      <= '0;
            d0_cnt_q    <= '0;
            d1_cnt_q    <= '0;
            d0_off_q    <= '0;
            d1_off_q    <= '0;
`ifdef ITA_ADDRGEN_D2_EN
            d2_stride_q <= '0;
            d2_off_q    <= '0;
            is3d_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            d0_cnt_q <= d0_cnt_d;
            d1_cnt_q <= d1_cnt_d;
            d0_off_q <= d0_off_d;
            d1_off_q <= d1_off_d;
`ifdef ITA_ADDRGEN_D2_EN
            d2_off_q <= d2_off_d;
`endif
            if (start) begin
                base_q      <= base_addr_i;
                d0_stride_q <= d0_stride_i;
                d1_stride_q <= d1_stride_i;
                tot_len_q   <= tot_len_i;
                d0_len_q    <= d0_len_i;
                d1_len_q    <= d1_len_i;
                is2d_q      <= |dim_enable_1h_i;
`ifdef ITA_ADDRGEN_D2_EN
                d2_stride_q <= d2_stride_i;
                is3d_q      <= dim_enable_1h_i[1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ita_hwpe_addrgen.sv
// tb_ita_hwpe_addrgen: directed self-checking bench for ita_hwpe_addrgen (honours ITA_ADDRGEN_D2_EN).
module tb_ita_hwpe_addrgen;

    logic        clk = 1'b0;
    logic        rst_ni, clear_i, req_start_i, addr_ready_i;
    logic [31:0] base_addr_i, d0_stride_i, d1_stride_i, d2_stride_i;
    logic [15:0] tot_len_i, d0_len_i, d1_len_i;
    logic [1:0]  dim_enable_1h_i;
    logic [31:0] addr_o;
    logic        addr_valid_o, last_o, ready_start_o, done_o;
    int          total = 0;
    int          bad = 0;

    ita_hwpe_addrgen dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .req_start_i(req_start_i),
        .base_addr_i(base_addr_i), .tot_len_i(tot_len_i), .d0_stride_i(d0_stride_i),
        .d0_len_i(d0_len_i), .d1_stride_i(d1_stride_i), .d1_len_i(d1_len_i),
        .d2_stride_i(d2_stride_i), .dim_enable_1h_i(dim_enable_1h_i), .addr_o(addr_o),
        .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i), .last_o(last_o),
        .ready_start_o(ready_start_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [31:0] base, input logic [15:0] tot, input logic [31:0] s0,
                       input logic [15:0] l0, input logic [31:0] s1, input logic [15:0] l1,
                       input logic [31:0] s2, input logic [1:0] dim);
        base_addr_i = base; tot_len_i = tot; d0_stride_i = s0; d0_len_i = l0;
        d1_stride_i = s1; d1_len_i = l1; d2_stride_i = s2; dim_enable_1h_i = dim;
    endtask

    // 2D job aborted after two handshakes by reset or clear, then restarted in full.
    task automatic abort_2d(input bit use_clear);
        logic [31:0] exp2d [4];
        exp2d = '{32'h00, 32'h80, 32'h10, 32'h90};
        cfg(0, 4, 128, 2, 16, 2, 0, 2'b01);
        addr_ready_i = 1'b1;
        req_start_i = 1'b1;
        tick();
        req_start_i = 1'b0;
        chk("abort_a0", addr_o, 32'h00);
        tick();
        chk("abort_a1", addr_o, 32'h80);
        tick();
        if (use_clear) clear_i = 1'b1; else rst_ni = 1'b0;
        tick();
        clear_i = 1'b0;
        rst_ni = 1'b1;
        chk("abort_valid", addr_valid_o, 0);
        chk("abort_rdy", ready_start_o, 1);
        chk("abort_done", done_o, 0);
        chk("abort_addr", addr_o, 0);
        tick();
        chk("abort_nodone", done_o, 0);
        req_start_i = 1'b1;
        tick();
        req_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("restart_addr", addr_o, exp2d[i]);
            chk("restart_last", last_o, i == 3);
            tick();
        end
        chk("restart_done", done_o, 1);
        tick();
    endtask

    initial begin
        logic [31:0] bp_addr [7];
        logic        bp_rdy [7];
        logic [31:0] exp3 [8];
        bp_addr = '{32'h1000, 32'h1004, 32'h1004, 32'h1004, 32'h1008, 32'h1008, 32'h100C};
        bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef ITA_ADDRGEN_D2_EN
        exp3 = '{32'd0, 32'd1, 32'd8, 32'd9, 32'd64, 32'd65, 32'd72, 32'd73};
`else
        exp3 = '{32'd0, 32'd1, 32'd8, 32'd9, 32'd16, 32'd17, 32'd24, 32'd25};
`endif
        rst_ni = 1'b0; clear_i = 1'b0; req_start_i = 1'b0; addr_ready_i = 1'b1;
        cfg(0, 0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        tick();
        chk("rst_valid", addr_valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rdy", ready_start_o, 1);
        chk("rst_addr", addr_o, 0);
        rst_ni = 1'b1;
        tick();

        // 1D, ready high; config changed after latch; start during DONE ignored
        cfg(32'h1000, 4, 4, 0, 0, 0, 0, 2'b00);
        req_start_i = 1'b1;
        tick();
        req_start_i = 1'b0;
        base_addr_i = 32'hDEAD0000;
        d0_stride_i = 32'h40;
        for (int i = 0; i < 4; i++) begin
            chk("1d_valid", addr_valid_o, 1);
            chk("1d_addr", addr_o, 32'h1000 + 4 * i);
            chk("1d_last", last_o, i == 3);
            chk("1d_rdy", ready_start_o, 0);
            tick();
        end
        chk("1d_done", done_o, 1);
        chk("1d_done_valid", addr_valid_o, 0);
        chk("1d_done_rdy", ready_start_o, 0);
        req_start_i = 1'b1;
        tick();
        req_start_i = 1'b0;
        chk("1d_idle_rdy", ready_start_o, 1);
        chk("1d_idle_done", done_o, 0);
        chk("1d_ignored_start", addr_valid_o, 0);
        tick();
        chk("1d_still_idle", addr_valid_o, 0);

        // 2D
        cfg(0, 4, 128, 2, 16, 2, 0, 2'b01);
        req_start_i = 1'b1;
        tick();
        req_start_i = 1'b0;
        chk("2d_a0", addr_o, 32'h00);
        tick();
        chk("2d_a1", addr_o, 32'h80);
        tick();
        chk("2d_a2", addr_o, 32'h10);
        tick();
        chk("2d_a3", addr_o, 32'h90);
        chk("2d_last", last_o, 1);
        tick();
        chk("2d_done", done_o, 1);
        tick();

        // 1D with backpressure
        cfg(32'h1000, 4, 4, 0, 0, 0, 0, 2'b00);
        req_start_i = 1'b1;
        tick();
        req_start_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            addr_ready_i = bp_rdy[i];
            chk("bp_valid", addr_valid_o, 1);
            chk("bp_addr", addr_o, bp_addr[i]);
            chk("bp_last", last_o, i == 6);
            chk("bp_done", done_o, 0);
            tick();
        end
        addr_ready_i = 1'b1;
        chk("bp_done_pulse", done_o, 1);
        chk("bp_done_valid", addr_valid_o, 0);
        tick();
        chk("bp_done_once", done_o, 0);

        // tot_len = 0
        cfg(32'h2000, 0, 4, 0, 0, 0, 0, 2'b00);
        req_start_i = 1'b1;
        tick();
        req_start_i = 1'b0;
        chk("zero_valid", addr_valid_o, 0);
        chk("zero_done", done_o, 1);
        chk("zero_rdy", ready_start_o, 0);
        tick();
        chk("zero_idle", ready_start_o, 1);
        chk("zero_done_off", done_o, 0);
        chk("zero_valid2", addr_valid_o, 0);

        abort_2d(1'b0);
        abort_2d(1'b1);

        // 3D request (2D behaviour when the d2 loop is not built)
        cfg(0, 8, 1, 2, 8, 2, 64, 2'b10);
        req_start_i = 1'b1;
        tick();
        req_start_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("3d_addr", addr_o, exp3[i]);
            chk("3d_last", last_o, i == 7);
            tick();
        end
        chk("3d_done", done_o, 1);
        tick();
        chk("3d_idle", ready_start_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ita_hwpe_addrgen.md
Name: ita_hwpe_addrgen

Overview:
Streamer address generator for one ITA HWPE stream (input, weight, bias or output).
- Consumes the per-stream `req_start` / `addressgen_ctrl` fields issued by the HWPE controller.
- Produces a valid/ready stream of byte addresses toward the TCDM source/sink.
- Returns the `ready_start` and `done` flags the controller polls before finishing a job.
- One instance per stream.

Parameters:
- AW, 32, address and stride width (bytes).
- LW, 16, width of `tot_len`, `d0_len` and `d1_len` counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- clear_i  in  1  synchronous soft clear, same effect as reset.
- req_start_i  in  1  start request; sampled only in IDLE.
- base_addr_i  in  AW  first address.
- tot_len_i  in  LW  total beats to issue.
- d0_stride_i  in  AW  inner stride.
- d0_len_i  in  LW  inner beats per d1 step.
- d1_stride_i  in  AW  middle stride.
- d1_len_i  in  LW  d1 steps per d2 step.
- d2_stride_i  in  AW  outer stride.
- dim_enable_1h_i  in  2  00=1D, 01=2D, 1x=3D.
- addr_o  out  AW  current address.
- addr_valid_o  out  1  address valid.
- addr_ready_i  in  1  consumer ready.
- last_o  out  1  current beat is final beat.
- ready_start_o  out  1  block is IDLE and accepts `req_start_i`.
- done_o  out  1  one-cycle pulse after final beat.

Behaviour:
- Reset and clear:
  - Reset (`rst_ni`=0 at a clock edge) or `clear_i`=1: state=IDLE, all counters 0.
  - Outputs: `addr_valid_o`=0, `last_o`=0, `done_o`=0, `ready_start_o`=1, `addr_o`=0.
  - Applies mid-run too: any beat in flight is dropped and no `done_o` is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - `req_start_i`=1 latches all config inputs.
  - `tot_len`≠0: go to RUN; cycle t start gives `addr_valid_o`=1 and `addr_o`=base at t+1.
  - `tot_len`=0: go to DONE, no beats issued.
  - Config inputs are don't-care after they are latched.
- RUN:
  - Address = base + d2_off + d1_off + d0_off, computed incrementally, modulo 2^AW; no multipliers.
  - Handshake: a beat completes on `addr_valid_o` & `addr_ready_i`.
  - While `addr_valid_o` & !`addr_ready_i`: `addr_o` and `last_o` are held stable.
  - `addr_valid_o` never drops without a handshake, except on reset or clear.
- Beat advance (on each handshake):
  - Beat counter +1; d0_off += d0_stride; d0 counter +1.
  - 2D or 3D, d0 counter reaching `d0_len`: d0_off=0, d0 counter=0, d1_off += d1_stride, d1 counter +1.
  - 3D only, d1 counter reaching `d1_len`: d1_off=0, d1 counter=0, d2_off += d2_stride.
  - 1D: `d0_len`/`d1_len` ignored, address purely linear.
  - `d0_len`=0 or `d1_len`=0: that dimension never wraps.
- Last beat:
  - `last_o`=1 exactly while beat counter = `tot_len`-1.
  - The handshake on that beat moves to DONE; `addr_valid_o`=0 the next cycle.
- DONE:
  - `done_o`=1 for exactly one cycle, `ready_start_o`=0.
  - Next state is IDLE unconditionally.
  - `req_start_i` during DONE is ignored; a start is accepted at the earliest in the following IDLE cycle.
- `ready_start_o`=1 iff state=IDLE; `req_start_i` in RUN or DONE is ignored.
- Throughput: with `addr_ready_i` held high, one beat per cycle, no bubbles.

Optional Feature:
ITA_ADDRGEN_D2_EN
- Defined: 3D mode exists as specified above (`dim_enable_1h_i`[1]=1 enables the d2 loop).
- Undefined: d2 logic is not built; `dim_enable_1h_i`[1] and `d2_stride_i` are ignored; 1x behaves as 01 (2D). Port list is unchanged.

Test Plan:
- 1D, ready high: start with base=0x1000, d0_stride=4, tot_len=4 -> addrs 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles from t+1; `last_o` on 0x100C; `done_o` pulse at t+5; `ready_start_o` high at t+6.
- 2D: base=0, d0_stride=128, d0_len=2, d1_stride=16, d1_len=2, tot_len=4, dim=01 -> 0x00, 0x80, 0x10, 0x90.
- Backpressure: 1D test with `addr_ready_i` pattern 1,0,0,1,0,1,1 -> every address held stable while stalled; 4 handshakes; `done_o` one cycle after the 4th; no address skipped or duplicated.
- tot_len=0: start at t -> `addr_valid_o` never high; `done_o`=1 at t+1; IDLE at t+2.
- Reset mid-run: 2D test, `rst_ni` low after 2 handshakes -> next cycle `addr_valid_o`=0, `ready_start_o`=1, no `done_o`; a new start re-issues from base. Repeat the same check with `clear_i`.
- With ITA_ADDRGEN_D2_EN: base=0, d0_stride=1, d0_len=2, d1_stride=8, d1_len=2, d2_stride=64, tot_len=8, dim=10 -> 0, 1, 8, 9, 64, 65, 72, 73. Without the macro -> 0, 1, 8, 9, 16, 17, 24, 25.
